// File: rtl/key_event_if.sv
// Key event bundle: debounced key level in, gesture pulses and busy flag out.
// The decoder takes the slave view; whatever drives the key takes the master view.
interface key_event_if;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;
    logic repeat_pulse;
    logic double_click;
    logic key_busy;

    modport master (
        output key_level,
        input  press_pulse, release_pulse, short_press, long_press,
               repeat_pulse, double_click, key_busy
    );

    modport slave (
        input  key_level,
        output press_pulse, release_pulse, short_press, long_press,
               repeat_pulse, double_click, key_busy
    );
endinterface

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into press/release, single/double click,
// long-press and auto-repeat pulses, all driven from registers.
module key_event_decoder #(
    parameter int unsigned LONG_CYC   = 25000000,
    parameter int unsigned REPEAT_CYC = 5000000,
    parameter int unsigned DCLICK_CYC = 15000000
) (
    input  logic         clk,
    input  logic         rst_n,
    key_event_if.slave   kif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESSED,
        S_LONG_HELD,
        S_WAIT_SECOND,
        S_SECOND_PRESSED
    } state_e;

    typedef struct packed {
        logic press;
        logic rel;
        logic short_p;
        logic long_p;
        logic rpt;
        logic dbl;
    } pulse_t;

    // Terminal counts: cnt restarts at 0 on entry, so N cycles end at N-1.
    localparam logic [31:0] LONG_LAST   = 32'(LONG_CYC - 1);
    localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CYC - 1);
    localparam logic [31:0] DCLICK_LAST = 32'(DCLICK_CYC - 1);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        k_r_q, k_r_d;
    pulse_t      pulse_q, pulse_d;

    logic fall;
    logic rise;
    logic cnt_restart;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        pulse_d     = '0;
        cnt_restart = 1'b0;
        k_r_d       = kif.key_level;

        fall = k_r_q & ~kif.key_level;
        rise = ~k_r_q & kif.key_level;

        // Key edges are tested before terminal counts so an edge always wins a tie.
        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d       = S_PRESSED;
                    pulse_d.press = 1'b1;
                end
            end

            S_PRESSED: begin
                if (rise) begin
                    state_d     = S_WAIT_SECOND;
                    pulse_d.rel = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d        = S_LONG_HELD;
                    pulse_d.long_p = 1'b1;
                end
            end

            S_LONG_HELD: begin
                if (rise) begin
                    state_d     = S_IDLE;
                    pulse_d.rel = 1'b1;
                end else if (cnt_q == REPEAT_LAST) begin
                    pulse_d.rpt = 1'b1;
                    cnt_restart = 1'b1;
                end
            end

            S_WAIT_SECOND: begin
                if (fall) begin
                    state_d       = S_SECOND_PRESSED;
                    pulse_d.press = 1'b1;
                end else if (cnt_q == DCLICK_LAST) begin
                    state_d         = S_IDLE;
                    pulse_d.short_p = 1'b1;
                end
            end

            S_SECOND_PRESSED: begin
                if (rise) begin
                    state_d     = S_IDLE;
                    pulse_d.rel = 1'b1;
                    pulse_d.dbl = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    // The first click is confirmed single at the moment the second becomes long.
                    state_d         = S_LONG_HELD;
                    pulse_d.short_p = 1'b1;
                    pulse_d.long_p  = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        cnt_d = (cnt_restart || (state_d != state_q)) ? '0 : cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            // NOTE: k_r resets to released, so a key already held when reset lifts reads as a fresh press.
            k_r_q   <= 1'b1;
            pulse_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop updates from the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_r_q   <= k_r_d;
            pulse_q <= pulse_d;
        end
    end

    assign kif.press_pulse   = pulse_q.press;
    assign kif.release_pulse = pulse_q.rel;
    assign kif.short_press   = pulse_q.short_p;
    assign kif.long_press    = pulse_q.long_p;
    assign kif.repeat_pulse  = pulse_q.rpt;
    assign kif.double_click  = pulse_q.dbl;
    assign kif.key_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: a timestamp-based gesture model checked every cycle,
// directed gestures with literal timing expectations, then randomized key activity.
module tb_key_event_decoder;

    localparam int LONG_CYC   = 20;
    localparam int REPEAT_CYC = 8;
    localparam int DCLICK_CYC = 10;

    // Event slots: 0 press, 1 release, 2 short, 3 long, 4 repeat, 5 double.
    localparam int EV_PRESS = 0, EV_REL = 1, EV_SHORT = 2, EV_LONG = 3, EV_REP = 4, EV_DBL = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    key_event_if kif ();

    key_event_decoder #(
        .LONG_CYC  (LONG_CYC),
        .REPEAT_CYC(REPEAT_CYC),
        .DCLICK_CYC(DCLICK_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kif  (kif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // {press, release, short, long, repeat, double, busy}
    logic [6:0] dut_out;
    assign dut_out = {kif.press_pulse, kif.release_pulse, kif.short_press, kif.long_press,
                      kif.repeat_pulse, kif.double_click, kif.key_busy};

    // Gesture model: remembers which phase the gesture is in and the clock edge at
    // which that phase began; timeouts are "edges elapsed since the phase began".
    typedef enum {G_IDLE, G_DOWN, G_HELD_LONG, G_GAP, G_DOWN_AGAIN} gesture_e;

    gesture_e    g_ph     = G_IDLE;
    logic        prev_lvl = 1'b1;
    int unsigned edge_no  = 0;
    int unsigned since    = 0;
    logic [6:0]  exp_out  = '0;

    task automatic enter(input gesture_e ph);
        g_ph  = ph;
        since = edge_no;
    endtask

    task automatic model_step();
        logic        went_down, went_up;
        int unsigned age;
        if (!rst_n) begin
            g_ph     = G_IDLE;
            prev_lvl = 1'b1;
            exp_out  = '0;
        end else begin
            went_down = prev_lvl && !kif.key_level;
            went_up   = !prev_lvl && kif.key_level;
            prev_lvl  = kif.key_level;
            edge_no++;
            age     = edge_no - since;
            exp_out = '0;
            case (g_ph)
                G_IDLE:
                    if (went_down) begin exp_out[6] = 1'b1; enter(G_DOWN); end
                G_DOWN:
                    if (went_up)                begin exp_out[5] = 1'b1; enter(G_GAP); end
                    else if (age == LONG_CYC)   begin exp_out[3] = 1'b1; enter(G_HELD_LONG); end
                G_HELD_LONG:
                    if (went_up)                 begin exp_out[5] = 1'b1; enter(G_IDLE); end
                    else if (age == REPEAT_CYC)  begin exp_out[2] = 1'b1; since = edge_no; end
                G_GAP:
                    if (went_down)               begin exp_out[6] = 1'b1; enter(G_DOWN_AGAIN); end
                    else if (age == DCLICK_CYC)  begin exp_out[4] = 1'b1; enter(G_IDLE); end
                G_DOWN_AGAIN:
                    if (went_up)                 begin exp_out[5] = 1'b1; exp_out[1] = 1'b1; enter(G_IDLE); end
                    else if (age == LONG_CYC)    begin exp_out[4] = 1'b1; exp_out[3] = 1'b1; enter(G_HELD_LONG); end
                default: enter(G_IDLE);
            endcase
            exp_out[0] = (g_ph != G_IDLE);
        end
    endtask

    // Event bookkeeping for the directed gestures.
    int tb_cyc = 0;
    int ev_cnt[6];
    int ev_first[6];
    int ev_last[6];

    task automatic clear_counts();
        for (int i = 0; i < 6; i++) begin
            ev_cnt[i]   = 0;
            ev_first[i] = -1;
            ev_last[i]  = -1;
        end
    endtask

    // Single compare process: model advances on each edge, outputs checked 2 time units later.
    initial begin
        logic [5:0] prev_pulses;
        prev_pulses = '0;
        clear_counts();
        forever begin
            @(posedge clk);
            model_step();
            #2;
            tb_cyc++;
            check("cycle_outputs", {25'd0, dut_out}, {25'd0, exp_out});
            check("pulse_width", {26'd0, prev_pulses & dut_out[6:1]}, 32'd0);
            prev_pulses = dut_out[6:1];
            for (int i = 0; i < 6; i++) begin
                if (dut_out[6 - i] === 1'b1) begin
                    if (ev_cnt[i] == 0) ev_first[i] = tb_cyc;
                    ev_cnt[i]++;
                    ev_last[i] = tb_cyc;
                end
            end
        end
    end

    task automatic drive(input logic lvl, input int n);
        kif.key_level = lvl;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        kif.key_level = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {25'd0, dut_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single click: short_press 10 cycles after release.
        clear_counts();
        drive(1'b0, 5);
        drive(1'b1, 30);
        check("click_press_n", ev_cnt[EV_PRESS], 1);
        check("click_release_n", ev_cnt[EV_REL], 1);
        check("click_short_n", ev_cnt[EV_SHORT], 1);
        check("click_long_dbl_n", ev_cnt[EV_LONG] + ev_cnt[EV_DBL], 0);
        check("click_hold_len", ev_last[EV_REL] - ev_first[EV_PRESS], 5);
        check("click_short_delay", ev_first[EV_SHORT] - ev_last[EV_REL], 10);

        // Double click.
        clear_counts();
        drive(1'b0, 5);
        drive(1'b1, 4);
        drive(1'b0, 5);
        drive(1'b1, 30);
        check("dbl_press_n", ev_cnt[EV_PRESS], 2);
        check("dbl_release_n", ev_cnt[EV_REL], 2);
        check("dbl_dbl_n", ev_cnt[EV_DBL], 1);
        check("dbl_short_n", ev_cnt[EV_SHORT], 0);
        check("dbl_with_release", ev_first[EV_DBL], ev_last[EV_REL]);

        // Long hold with auto-repeat.
        clear_counts();
        drive(1'b0, 40);
        drive(1'b1, 30);
        check("long_long_n", ev_cnt[EV_LONG], 1);
        check("long_at_20", ev_first[EV_LONG] - ev_first[EV_PRESS], 20);
        check("long_repeat_n", ev_cnt[EV_REP], 2);
        check("long_repeat_28", ev_first[EV_REP] - ev_first[EV_PRESS], 28);
        check("long_repeat_36", ev_last[EV_REP] - ev_first[EV_PRESS], 36);
        check("long_release_40", ev_first[EV_REL] - ev_first[EV_PRESS], 40);
        check("long_short_n", ev_cnt[EV_SHORT], 0);

        // Second press lands exactly on the double-click timeout edge: edge wins.
        clear_counts();
        drive(1'b0, 5);
        drive(1'b1, 10);
        drive(1'b0, 5);
        drive(1'b1, 30);
        check("edge_tie_press_n", ev_cnt[EV_PRESS], 2);
        check("edge_tie_short_n", ev_cnt[EV_SHORT], 0);
        check("edge_tie_dbl_n", ev_cnt[EV_DBL], 1);

        // One cycle later the window has closed: two separate single clicks.
        clear_counts();
        drive(1'b0, 5);
        drive(1'b1, 11);
        drive(1'b0, 5);
        drive(1'b1, 30);
        check("late_short_n", ev_cnt[EV_SHORT], 2);
        check("late_dbl_n", ev_cnt[EV_DBL], 0);
        check("late_press_n", ev_cnt[EV_PRESS], 2);

        // Second press held long: short and long on the same cycle, no double click.
        clear_counts();
        drive(1'b0, 5);
        drive(1'b1, 4);
        drive(1'b0, 25);
        drive(1'b1, 30);
        check("second_long_short_n", ev_cnt[EV_SHORT], 1);
        check("second_long_long_n", ev_cnt[EV_LONG], 1);
        check("second_long_same_cyc", ev_first[EV_SHORT], ev_first[EV_LONG]);
        check("second_long_dbl_n", ev_cnt[EV_DBL], 0);

        // Reset during a long hold, key released while in reset.
        clear_counts();
        drive(1'b0, 30);
        check("pre_reset_long_n", ev_cnt[EV_LONG], 1);
        rst_n = 1'b0;
        kif.key_level = 1'b1;
        #1;
        check("reset_mid_long", {25'd0, dut_out}, 32'd0);
        repeat (3) @(negedge clk);
        clear_counts();
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_reset_quiet", ev_cnt[0] + ev_cnt[1] + ev_cnt[2] + ev_cnt[3] + ev_cnt[4] + ev_cnt[5], 0);
        drive(1'b0, 5);
        drive(1'b1, 30);
        check("post_reset_press_n", ev_cnt[EV_PRESS], 1);
        check("post_reset_short_n", ev_cnt[EV_SHORT], 1);

        // Reset released with the key already down: immediate press.
        rst_n = 1'b0;
        kif.key_level = 1'b0;
        repeat (2) @(negedge clk);
        clear_counts();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("held_at_reset_press_n", ev_cnt[EV_PRESS], 1);
        drive(1'b1, 30);
        check("held_at_reset_release_n", ev_cnt[EV_REL], 1);
        check("held_at_reset_short_n", ev_cnt[EV_SHORT], 1);

        // Randomized key activity with occasional resets, checked by the model.
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_n = 1'b1;
            end
            case ($urandom_range(0, 3))
                0:       n = int'($urandom_range(1, 4));
                1:       n = int'($urandom_range(8, 12));
                2:       n = int'($urandom_range(18, 22));
                default: n = int'($urandom_range(25, 45));
            endcase
            drive(1'($urandom_range(0, 1)), n);
        end
        drive(1'b1, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter LONG_CYC, default 25000000, cycles a press must be held to count as long (>=2).
REQ-002 SHALL have parameter REPEAT_CYC, default 5000000, cycles between auto-repeat pulses while long-held (>=2).
REQ-003 SHALL have parameter DCLICK_CYC, default 15000000, window in cycles after a release in which a second press forms a double click (>=2).
REQ-004 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port key_level  input  1  debounced key level, synchronous to clk; 1 = released (idle), 0 = pressed.
REQ-007 SHALL have port press_pulse  output  1  one-cycle pulse on each press.
REQ-008 SHALL have port release_pulse  output  1  one-cycle pulse on each release.
REQ-009 SHALL have port short_press  output  1  one-cycle pulse: single click confirmed.
REQ-010 SHALL have port long_press  output  1  one-cycle pulse: hold reached LONG_CYC.
REQ-011 SHALL have port repeat_pulse  output  1  one-cycle pulse every REPEAT_CYC while long-held.
REQ-012 SHALL have port double_click  output  1  one-cycle pulse: second release inside window.
REQ-013 SHALL have port key_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 SHALL register key_level into k_r each cycle; fall = k_r & ~key_level, rise = ~k_r & key_level.
REQ-015 SHALL register all outputs; each event pulse is high for exactly the one cycle following the clk edge at which its condition is detected.
REQ-016 SHALL use one 32-bit cycle counter cnt, cleared on every state transition, incremented otherwise.
REQ-017 SHALL implement states IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED.
REQ-018 IDLE: fall -> PRESSED, press_pulse.
REQ-019 PRESSED: rise -> WAIT_SECOND, release_pulse; else cnt==LONG_CYC-1 -> LONG_HELD, long_press.
REQ-020 LONG_HELD: rise -> IDLE, release_pulse, no short_press; else cnt==REPEAT_CYC-1 -> repeat_pulse, cnt cleared, stay.
REQ-021 WAIT_SECOND: fall -> SECOND_PRESSED, press_pulse; else cnt==DCLICK_CYC-1 -> IDLE, short_press.
REQ-022 SECOND_PRESSED: rise -> IDLE, release_pulse and double_click same cycle; else cnt==LONG_CYC-1 -> LONG_HELD, short_press and long_press same cycle.
REQ-023 Simultaneous key edge and counter terminal value in one cycle: key edge SHALL win.
REQ-024 short_press, long_press, double_click SHALL be mutually exclusive per gesture except per REQ-022.
REQ-025 key_busy SHALL be combinational decode of state != IDLE.

Reset
REQ-026 On rst_n low SHALL immediately force state IDLE, cnt 0, k_r 1, all pulse outputs 0, key_busy 0.
REQ-027 After rst_n deasserts with key_level already 0, SHALL detect fall on first cycle and issue press_pulse.
REQ-028 Reset mid-gesture SHALL discard the gesture; no pending pulse emitted after release of reset.

Verification (LONG_CYC=20, REPEAT_CYC=8, DCLICK_CYC=10)
REQ-029 key low 5 cycles then high -> press_pulse, release_pulse, short_press 10 cycles after release_pulse, no double_click/long_press.
REQ-030 low 5, high 4, low 5, high -> 2x press_pulse, 2x release_pulse, 1x double_click with second release_pulse, no short_press.
REQ-031 low 40 cycles then high -> long_press 20 cycles after press_pulse, repeat_pulse at +28 and +36, release_pulse, no short_press.
REQ-032 second fall on exact WAIT_SECOND timeout cycle -> press_pulse, no short_press; subsequent release -> double_click.
REQ-033 rst_n pulsed low during LONG_HELD, key released during reset -> all outputs 0 within reset, no pulses afterward until next fall.
REQ-034 bench SHALL check every pulse output is never high two consecutive cycles.
